poly_reduce_out: RTL and testbench
==================================

# poly_reduce_out

Downstream stage of the polynomial `accumulator`. It consumes the accumulator's coefficient-pair output stream (`addr_out`, `data_a_out`, `data_b_out`) and reduces each 16-bit lane to canonical form mod q = 3329 with a 2-stage Barrett pipeline. It presents the 12-bit results on a valid/ready interface to the packer/output buffer. It tracks one 128-pair polynomial per run and signals completion.

## Interface
- `N_PAIRS`, default 128: coefficient pairs per polynomial (256 coefficients).
- `ADDR_W`, default 7: pair address width.
- `IN_W`, default 16: input lane width.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `set`  in  1: block enable. While low, all state is frozen, `in_ready` = 0, and outputs hold.
- `start`  in  1: one-cycle pulse in IDLE that begins a run.
- `in_valid`  in  1: accumulator output pair valid.
- `in_ready`  out  1: pair accepted when `in_valid && in_ready`.
- `addr_in`  in  ADDR_W: pair address (from accumulator `addr_out`).
- `data_a_in`, `data_b_in`  in  IN_W: lane values (from `data_a_out`/`data_b_out`).
- `out_valid`  out  1: reduced pair valid.
- `out_ready`  in  1: downstream accepts.
- `out_addr`  out  ADDR_W: address travelling with the pair.
- `out_a`, `out_b`  out  12: reduced coefficients, 0..3328.
- `done`  out  1: one-cycle pulse at end of run.
- `err`  out  1: sticky address-sequence error (see Configuration).

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on `start && set`. `start` in any other state is ignored.
- RUN: `in_ready` = `set && !(s2_valid && !out_ready)`. Each accept increments the 8-bit `cnt`.
- RUN -> FLUSH on the accept that makes `cnt` == N_PAIRS. `in_ready` = 0 in FLUSH.
- FLUSH -> DONE when the pipeline is empty and the last output handshake has completed.
- DONE -> IDLE unconditionally. `done` = 1 only in DONE. `cnt` clears on entering IDLE.
- Reduction per lane: t = (x * 20159) >> 26; r = x − t*3329; if r ≥ 3329 then r −= 3329.
    - Product is 31 bits.
    - r is formed in 13 bits before the correction step.
    - At most one correction is needed for any 16-bit x.
- Pipeline stages:
    - s1 registers x, t, and the address.
    - s2 registers the corrected r and the address.
- Stall-all pipeline: when `s2_valid && !out_ready`, neither s1 nor s2 advances.
- Outputs are driven from s2 registers: `out_valid` = `s2_valid`.
- Throughput: one pair per cycle with no bubbles when `out_ready` stays high.
- Simultaneous output handshake and new input accept in the same cycle is legal.
- `set` low mid-run: pipeline and counters freeze. Resuming continues with no loss or duplication.
- Reset mid-run: asynchronously clears all state. In-flight pairs are discarded, and the FSM returns to IDLE.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `out_addr` 0, `out_a` 0, `out_b` 0, `done` 0, `err` 0; FSM in IDLE.
- `start` at cycle n: state is RUN at n+1, and `in_ready` is high from n+1.
- Latency: a pair accepted at cycle n appears on `out_*` with `out_valid` high at n+2 (unstalled).
- While `out_valid && !out_ready`: `out_valid`, `out_addr`, `out_a`, and `out_b` are held stable.
- Final output handshake at cycle m: `done` pulses at m+1, and the FSM is in IDLE at m+2.
- A full unstalled run takes 128 accept cycles + 2 + 1 (DONE).

## Configuration
- `POLY_REDUCE_ADDR_CHECK_EN` defined:
    - Each accepted `addr_in` is compared to `cnt[ADDR_W-1:0]`.
    - A mismatch sets `err` in the cycle after the accept.
    - `err` stays set until the next `start` or reset.
    - Data still flows on a mismatch; `out_addr` carries the received address.
- Macro undefined: no comparator, `err` tied 0, and addresses pass through unchecked.

## Structure
- `kyber_pkg` holds: `KYBER_Q` = 3329, `BARRETT_M` = 20159, `BARRETT_SHIFT` = 26, `COEF_W` = 12, `ADDR_W` = 7, `N_PAIRS` = 128, and the FSM state enum.
- Sub-module `barrett_reduce`:
    - 2-stage pipeline with a stage-advance enable input.
    - Instantiated twice, once per lane.
- FSM, counter, address check, and handshake logic live in the top module.

## Test plan
- Reset then `start`; feed 128 pairs with addr 0..127 and a = b = addr + 5, `out_ready` = 1 -> outputs a = b = addr + 5 in order, first at 2 cycles after the first accept, `done` pulse, `err` = 0.
- Lane values 0, 3328, 3329, 6658, 65535 -> 0, 3328, 0, 0, 2284.
- `out_ready` low for 4 cycles mid-run -> `in_ready` drops the same cycle, the held output is stable, and no pair is lost or duplicated across all 128.
- With the macro defined, feed addr sequence 0, 1, 3 -> `err` rises the cycle after the third accept and stays high until the next `start`.
- Toggle `set` low for 3 cycles and assert reset mid-run at pair 60 -> freeze with no state change; then all outputs return to reset values, IDLE, and a new `start` completes a clean run.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants and FSM state type for the polynomial reduction output stage.
package kyber_pkg;

   localparam int KYBER_Q       = 3329;
   localparam int BARRETT_M     = 20159;
   localparam int BARRETT_SHIFT = 26;
   localparam int COEF_W        = 12;
   localparam int ADDR_W        = 7;
   localparam int N_PAIRS       = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reduction of one lane to 0..KYBER_Q-1.
// Stage 1 holds x and the quotient estimate t; stage 2 holds the corrected remainder.
// Both stages load only when adv is high, so the caller can stall the whole pipe.
module barrett_reduce
   import kyber_pkg::*;
#(
   parameter int IN_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   input  logic [IN_W-1:0]   x_in,
   output logic [COEF_W-1:0] r_out
);

   localparam int PROD_W = IN_W + 15;
   localparam int T_W    = PROD_W - BARRETT_SHIFT;

   logic [IN_W-1:0]   x_q, x_d;
   logic [T_W-1:0]    t_q, t_d;
   logic [COEF_W-1:0] r_q, r_d;
   logic [12:0]       r_raw;

   // quotient estimate, remainder in 13 bits, single conditional correction
   always_comb begin
      x_d   = x_in;
      t_d   = T_W'((PROD_W'(x_in) * PROD_W'(BARRETT_M)) >> BARRETT_SHIFT);
      r_raw = 13'(x_q - IN_W'(t_q) * IN_W'(KYBER_Q));
      if (r_raw >= 13'(KYBER_Q)) begin
         r_d = COEF_W'(r_raw - 13'(KYBER_Q));
      end else begin
         r_d = COEF_W'(r_raw);
      end
   end

   // pipeline registers, advancing together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         t_q <= '0;
         r_q <= '0;
      end else if (adv) begin
         x_q <= x_d;
         t_q <= t_d;
         r_q <= r_d;
      end
   end

   assign r_out = r_q;

endmodule

// File: rtl/poly_reduce_out.sv
// Reduces the accumulator's coefficient-pair stream mod q and hands it to the packer.
// One run covers N_PAIRS pairs; done pulses once the last result has been taken.
// Optional build macro POLY_REDUCE_ADDR_CHECK_EN adds a sticky address-sequence check on err.
//
// state    | meaning
// ST_IDLE  | waiting for start, in_ready low
// ST_RUN   | accepting pairs until N_PAIRS have been taken
// ST_FLUSH | no more input, draining the two pipeline stages
// ST_DONE  | single-cycle done pulse, back to idle next
module poly_reduce_out
   import kyber_pkg::*;
#(
   parameter int N_PAIRS = 128,
   parameter int ADDR_W  = 7,
   parameter int IN_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [IN_W-1:0]   data_a_in,
   input  logic [IN_W-1:0]   data_b_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [COEF_W-1:0] out_a,
   output logic [COEF_W-1:0] out_b,
   output logic              done,
   output logic              err
);

   localparam logic [7:0] LAST_CNT = 8'(N_PAIRS - 1);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              s1_valid_q, s1_valid_d;
   logic              s2_valid_q, s2_valid_d;
   logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
   logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
   logic              adv;
   logic              accept;

   // a held output blocks both stages; set low freezes everything
   assign adv      = set && !(s2_valid_q && !out_ready);
   assign in_ready = adv && (state_q == ST_RUN);
   assign accept   = in_valid && in_ready;

   // next state and pair counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (set && start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (accept) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == LAST_CNT) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (set && !s1_valid_q && (!s2_valid_q || out_ready)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (set) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // valid and address tracking alongside the lane pipelines
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_addr_d  = s1_addr_q;
      s2_valid_d = s2_valid_q;
      s2_addr_d  = s2_addr_q;
      if (adv) begin
         s1_valid_d = accept;
         s2_valid_d = s1_valid_q;
         if (accept)     s1_addr_d = addr_in;
         if (s1_valid_q) s2_addr_d = s1_addr_q;
      end
   end

   // pipeline control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_addr_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s2_valid_q <= s2_valid_d;
         s2_addr_q  <= s2_addr_d;
      end
   end

   barrett_reduce #(.IN_W(IN_W)) u_lane_a (
      .clk   (clk),
      .rst_n (reset),
      .adv   (adv),
      .x_in  (data_a_in),
      .r_out (out_a)
   );

   barrett_reduce #(.IN_W(IN_W)) u_lane_b (
      .clk   (clk),
      .rst_n (reset),
      .adv   (adv),
      .x_in  (data_b_in),
      .r_out (out_b)
   );

   assign out_valid = s2_valid_q;
   assign out_addr  = s2_addr_q;
   assign done      = (state_q == ST_DONE);

`ifdef POLY_REDUCE_ADDR_CHECK_EN
   logic err_q, err_d;

   // sticky flag for an out-of-sequence address, cleared by the next start
   always_comb begin
      err_d = err_q;
      if ((state_q == ST_IDLE) && set && start) begin
         err_d = 1'b0;
      end else if (accept && (addr_in != cnt_q[ADDR_W-1:0])) begin
         err_d = 1'b1;
      end
   end

   // error flag register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_reduce_out.sv
// Directed bench for poly_reduce_out with a scoreboard of expected reduced pairs.
module tb_poly_reduce_out;

`ifdef POLY_REDUCE_ADDR_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   typedef struct {
      logic [6:0]  addr;
      logic [11:0] a;
      logic [11:0] b;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, set, start, in_valid, out_ready;
   logic        in_ready, out_valid, done, err;
   logic [6:0]  addr_in, out_addr;
   logic [15:0] data_a_in, data_b_in;
   logic [11:0] out_a, out_b;

   exp_t sb[$];
   int   vec = 0;
   int   miss = 0;
   int   cyc = 0;
   int   n_out, first_acc, first_out, last_hs;
   bit   hold_prev = 0;
   logic [6:0]  h_addr;
   logic [11:0] h_a, h_b;

   poly_reduce_out dut (
      .clk       (clk),
      .reset     (reset),
      .set       (set),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .addr_in   (addr_in),
      .data_a_in (data_a_in),
      .data_b_in (data_b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_a     (out_a),
      .out_b     (out_b),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [11:0] ref_red(input logic [15:0] x);
      return 12'(int'(x) % 3329);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard push on accept, pop/compare on output handshake, hold-stability check
   always @(negedge clk) begin
      if (!reset) begin
         hold_prev = 0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_addr", 32'(out_addr), 32'(h_addr));
            chk("hold_a", 32'(out_a), 32'(h_a));
            chk("hold_b", 32'(out_b), 32'(h_b));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_addr", 32'(out_addr), 32'(e.addr));
               chk("out_a", 32'(out_a), 32'(e.a));
               chk("out_b", 32'(out_b), 32'(e.b));
            end
            n_out++;
            last_hs = cyc;
            if (first_out < 0) first_out = cyc;
         end
         if (in_valid && in_ready) begin
            exp_t e;
            e.addr = addr_in;
            e.a    = ref_red(data_a_in);
            e.b    = ref_red(data_b_in);
            sb.push_back(e);
            if (first_acc < 0) first_acc = cyc;
         end
         hold_prev = out_valid && !out_ready;
         h_addr = out_addr;
         h_a    = out_a;
         h_b    = out_b;
      end
   end

   task automatic pair_of(input int mode, input int i, output logic [6:0] a,
                          output logic [15:0] da, output logic [15:0] db);
      logic [15:0] edges [5];
      edges = '{16'd0, 16'd3328, 16'd3329, 16'd6658, 16'd65535};
      a = 7'(i);
      case (mode)
         0: begin da = 16'(i + 5); db = 16'(i + 5); end
         1: begin
            if (i < 5) begin da = edges[i]; db = edges[4 - i]; end
            else begin da = 16'(i * 513); db = 16'(65535 - i * 37); end
         end
         default: begin
            if (i == 2) a = 7'd3;
            da = 16'(i * 211 + 7);
            db = 16'(i * 97);
         end
      endcase
   endtask

   task automatic send(input logic [6:0] a, input logic [15:0] da, input logic [15:0] db);
      bit acc;
      int g;
      addr_in = a; data_a_in = da; data_b_in = db; in_valid = 1'b1;
      g = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         g++;
         @(posedge clk);
         #1;
      end while (!acc && g < 64);
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic send_range(input int mode, input int lo, input int hi);
      logic [6:0]  a;
      logic [15:0] da, db;
      for (int i = lo; i < hi; i++) begin
         pair_of(mode, i, a, da, db);
         send(a, da, db);
      end
   endtask

   task automatic new_run();
      n_out = 0; first_acc = -1; first_out = -1; last_hs = -100;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("start_in_ready", 32'(in_ready), 32'd1);
      chk("start_err_clr", 32'(err), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic finish_run();
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!done && g < 40);
      chk("done_seen", 32'(done), 32'd1);
      chk("done_cycle", 32'(cyc), 32'(last_hs + 1));
      chk("out_count", 32'(n_out), 32'd128);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("latency", 32'(first_out - first_acc), 32'd2);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic check_reset_vals();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_addr", 32'(out_addr), 32'd0);
      chk("rst_out_a", 32'(out_a), 32'd0);
      chk("rst_out_b", 32'(out_b), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
   endtask

   initial begin
      logic [6:0]  f_addr;
      logic [11:0] f_a, f_b;

      reset = 1'b0; set = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      addr_in = '0; data_a_in = '0; data_b_in = '0;
      new_run();
      #2;
      check_reset_vals();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // run 1: a = b = addr + 5, no back-pressure
      new_run();
      do_start();
      send_range(0, 0, 128);
      finish_run();
      chk("run1_err", 32'(err), 32'd0);

      // run 2: lane boundary values, 4-cycle output stall mid-run
      new_run();
      do_start();
      fork
         send_range(1, 0, 128);
         begin
            for (int g = 0; g < 2000 && n_out < 40; g++) @(negedge clk);
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'd0);
               chk("stall_out_valid", 32'(out_valid), 32'd1);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      finish_run();

      // run 3: address sequence 0, 1, 3, ...
      new_run();
      do_start();
      send_range(2, 0, 2);
      @(negedge clk);
      chk("err_before_gap", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      send_range(2, 2, 3);
      @(negedge clk);
      chk("err_after_gap", 32'(err), 32'(EXP_ERR));
      @(posedge clk);
      #1;
      send_range(2, 3, 128);
      finish_run();
      chk("err_sticky", 32'(err), 32'(EXP_ERR));

      // run 4: freeze with set low, resume, then reset mid-run
      new_run();
      do_start();
      send_range(0, 0, 60);
      set = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      f_addr = out_addr; f_a = out_a; f_b = out_b;
      repeat (3) begin
         @(negedge clk);
         chk("freeze_in_ready", 32'(in_ready), 32'd0);
         chk("freeze_valid", 32'(out_valid), 32'd1);
         chk("freeze_addr", 32'(out_addr), 32'(f_addr));
         chk("freeze_a", 32'(out_a), 32'(f_a));
         chk("freeze_b", 32'(out_b), 32'(f_b));
      end
      @(posedge clk);
      #1 set = 1'b1;
      out_ready = 1'b1;
      send_range(0, 60, 64);
      chk("resume_count", 32'(n_out + sb.size()), 32'd64);
      reset = 1'b0;
      #1;
      check_reset_vals();
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      new_run();
      do_start();
      send_range(0, 0, 128);
      finish_run();
      chk("run5_err", 32'(err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
